// File: rtl/sm4_axis8_arbiter.sv
// Packet-level round-robin arbiter sharing one byte-wide SM4 padding engine between two channels.
// Optional feature: define SM4_ARB_KEY_CACHE_EN to also force a key reload when a channel's key/sel changes.
module sm4_axis8_arbiter #(
    parameter int KEY_WAIT = 32,
    parameter int MAX_OUT  = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] key0,
    input  logic [127:0] key1,
    input  logic         sel0,
    input  logic         sel1,
    input  logic [7:0]   s0_axis_tdata,
    input  logic         s0_axis_tvalid,
    input  logic         s0_axis_tlast,
    input  logic [7:0]   s0_axis_tuser,
    output logic         s0_axis_tready,
    input  logic [7:0]   s1_axis_tdata,
    input  logic         s1_axis_tvalid,
    input  logic         s1_axis_tlast,
    input  logic [7:0]   s1_axis_tuser,
    output logic         s1_axis_tready,
    output logic [7:0]   m0_axis_tdata,
    output logic         m0_axis_tvalid,
    output logic         m0_axis_tlast,
    output logic [7:0]   m0_axis_tuser,
    output logic [7:0]   m1_axis_tdata,
    output logic         m1_axis_tvalid,
    output logic         m1_axis_tlast,
    output logic [7:0]   m1_axis_tuser,
    output logic         eng_sm4_vld,
    output logic [127:0] eng_sm4_key,
    output logic         eng_sm4_sel,
    output logic [7:0]   eng_s_axis_tdata,
    output logic         eng_s_axis_tvalid,
    output logic         eng_s_axis_tlast,
    output logic [7:0]   eng_s_axis_tuser,
    input  logic         eng_s_axis_tready,
    input  logic [7:0]   eng_m_axis_tdata,
    input  logic         eng_m_axis_tvalid,
    input  logic         eng_m_axis_tlast,
    input  logic [7:0]   eng_m_axis_tuser,
    output logic         busy,
    output logic         err_orphan
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int CW = PW + 1;
    localparam int WW = (KEY_WAIT > 1) ? $clog2(KEY_WAIT) : 1;
    localparam logic [WW-1:0] WAIT_LAST = WW'(KEY_WAIT - 1);
    localparam logic [CW-1:0] OUT_FULL  = CW'(MAX_OUT);

    typedef enum logic [2:0] {IDLE, DRAIN, LOAD, WAIT, XFER} state_t;

    state_t        state_q, state_d;
    logic          grant_q, grant_d;
    logic          lastGrant_q, lastGrant_d;
    logic          loadedVld_q, loadedVld_d;
    logic          loadedCh_q, loadedCh_d;
    logic [127:0]  key_q, key_d;
    logic          sel_q, sel_d;
    logic [WW-1:0] waitCnt_q, waitCnt_d;
    logic [CW-1:0] outstanding_q, outstanding_d;
    logic [PW-1:0] wrPtr_q, rdPtr_q;
    logic [MAX_OUT-1:0] idFifo_q;
    logic          orphan_q;

    logic          anyValid, pickCh, keyMatch;
    logic          fifoFull, fifoEmpty, fifoHead;
    logic          push, pop, inXfer;
    logic [127:0]  grantKey;
    logic          grantSel;
    logic [7:0]    gData, gUser;
    logic          gValid, gLast;

    assign anyValid  = s0_axis_tvalid | s1_axis_tvalid;
    assign pickCh    = (s0_axis_tvalid & s1_axis_tvalid) ? ~lastGrant_q : s1_axis_tvalid;
    assign fifoEmpty = (outstanding_q == '0);
    assign fifoFull  = (outstanding_q == OUT_FULL);
    assign fifoHead  = idFifo_q[rdPtr_q];

`ifdef SM4_ARB_KEY_CACHE_EN
    assign keyMatch = pickCh ? ((key1 == key_q) && (sel1 == sel_q))
                             : ((key0 == key_q) && (sel0 == sel_q));
`else
    assign keyMatch = 1'b1;
`endif

    assign grantKey = grant_q ? key1 : key0;
    assign grantSel = grant_q ? sel1 : sel0;
    assign gData    = grant_q ? s1_axis_tdata  : s0_axis_tdata;
    assign gUser    = grant_q ? s1_axis_tuser  : s0_axis_tuser;
    assign gValid   = grant_q ? s1_axis_tvalid : s0_axis_tvalid;
    assign gLast    = grant_q ? s1_axis_tlast  : s0_axis_tlast;

    // The key goes out combinationally during LOAD and is then held from the register.
    assign eng_sm4_key = (state_q == LOAD) ? grantKey : key_q;
    assign eng_sm4_sel = (state_q == LOAD) ? grantSel : sel_q;

    assign inXfer            = (state_q == XFER);
    assign eng_s_axis_tvalid = inXfer & gValid;
    assign eng_s_axis_tdata  = inXfer ? gData : 8'h00;
    assign eng_s_axis_tlast  = inXfer & gLast;
    assign eng_s_axis_tuser  = inXfer ? gUser : 8'h00;

    always_comb begin
        state_d        = state_q;
        grant_d        = grant_q;
        lastGrant_d    = lastGrant_q;
        loadedVld_d    = loadedVld_q;
        loadedCh_d     = loadedCh_q;
        key_d          = key_q;
        sel_d          = sel_q;
        waitCnt_d      = waitCnt_q;
        push           = 1'b0;
        eng_sm4_vld    = 1'b0;
        s0_axis_tready = 1'b0;
        s1_axis_tready = 1'b0;
        case (state_q)
            IDLE: begin
                if (anyValid && !fifoFull) begin
                    grant_d = pickCh;
                    if (loadedVld_q && (loadedCh_q == pickCh) && keyMatch) begin
                        state_d = XFER;
                    end else begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                // Never swap keys under blocks still inside the engine.
                if (outstanding_q == '0) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                eng_sm4_vld = 1'b1;
                key_d       = grantKey;
                sel_d       = grantSel;
                loadedVld_d = 1'b1;
                loadedCh_d  = grant_q;
                waitCnt_d   = '0;
                state_d     = WAIT;
            end
            WAIT: begin
                if (waitCnt_q == WAIT_LAST) begin
                    state_d = XFER;
                end else begin
                    waitCnt_d = waitCnt_q + WW'(1);
                end
            end
            XFER: begin
                s0_axis_tready = ~grant_q & eng_s_axis_tready;
                s1_axis_tready =  grant_q & eng_s_axis_tready;
                if (gValid && eng_s_axis_tready && gLast) begin
                    push        = 1'b1;
                    lastGrant_d = grant_q;
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign pop = eng_m_axis_tvalid & eng_m_axis_tlast & ~fifoEmpty;

    always_comb begin
        outstanding_d = outstanding_q;
        case ({push, pop})
            2'b10:   outstanding_d = outstanding_q + CW'(1);
            2'b01:   outstanding_d = outstanding_q - CW'(1);
            default: outstanding_d = outstanding_q;
        endcase
    end

    assign m0_axis_tdata  = eng_m_axis_tdata;
    assign m0_axis_tlast  = eng_m_axis_tlast;
    assign m0_axis_tuser  = eng_m_axis_tuser;
    assign m0_axis_tvalid = eng_m_axis_tvalid & ~fifoEmpty & ~fifoHead;
    assign m1_axis_tdata  = eng_m_axis_tdata;
    assign m1_axis_tlast  = eng_m_axis_tlast;
    assign m1_axis_tuser  = eng_m_axis_tuser;
    assign m1_axis_tvalid = eng_m_axis_tvalid & ~fifoEmpty & fifoHead;

    assign busy       = (state_q != IDLE) | ~fifoEmpty;
    assign err_orphan = orphan_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            grant_q       <= 1'b0;
            lastGrant_q   <= 1'b1;
            loadedVld_q   <= 1'b0;
            loadedCh_q    <= 1'b0;
            key_q         <= '0;
            sel_q         <= 1'b0;
            waitCnt_q     <= '0;
            outstanding_q <= '0;
            wrPtr_q       <= '0;
            rdPtr_q       <= '0;
            idFifo_q      <= '0;
            orphan_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            lastGrant_q   <= lastGrant_d;
            loadedVld_q   <= loadedVld_d;
            loadedCh_q    <= loadedCh_d;
            key_q         <= key_d;
            sel_q         <= sel_d;
            waitCnt_q     <= waitCnt_d;
            outstanding_q <= outstanding_d;
            if (push) begin
                idFifo_q[wrPtr_q] <= grant_q;
                wrPtr_q           <= wrPtr_q + PW'(1);
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + PW'(1);
            end
            if (eng_m_axis_tvalid && fifoEmpty) begin
                orphan_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sm4_axis8_arbiter.sv
// Bench for sm4_axis8_arbiter: stub padding engine, random traffic, per-channel expected-output queues.
`timescale 1ns/1ps
module tb_sm4_axis8_arbiter;
    localparam int KEY_WAIT = 32;
    localparam int MAX_OUT  = 4;
    localparam int TIMEOUT  = 3000;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [127:0] key0, key1;
    logic         sel0, sel1;
    logic [7:0]   s0_axis_tdata, s1_axis_tdata, s0_axis_tuser, s1_axis_tuser;
    logic         s0_axis_tvalid, s1_axis_tvalid, s0_axis_tlast, s1_axis_tlast;
    logic         s0_axis_tready, s1_axis_tready;
    logic [7:0]   m0_axis_tdata, m1_axis_tdata, m0_axis_tuser, m1_axis_tuser;
    logic         m0_axis_tvalid, m1_axis_tvalid, m0_axis_tlast, m1_axis_tlast;
    logic         eng_sm4_vld, eng_sm4_sel;
    logic [127:0] eng_sm4_key;
    logic [7:0]   eng_s_axis_tdata, eng_s_axis_tuser;
    logic         eng_s_axis_tvalid, eng_s_axis_tlast, eng_s_axis_tready;
    logic [7:0]   eng_m_axis_tdata, eng_m_axis_tuser;
    logic         eng_m_axis_tvalid, eng_m_axis_tlast;
    logic         busy, err_orphan;

    always #5 clk = ~clk;

    sm4_axis8_arbiter #(.KEY_WAIT(KEY_WAIT), .MAX_OUT(MAX_OUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .key0(key0), .key1(key1), .sel0(sel0), .sel1(sel1),
        .s0_axis_tdata(s0_axis_tdata), .s0_axis_tvalid(s0_axis_tvalid),
        .s0_axis_tlast(s0_axis_tlast), .s0_axis_tuser(s0_axis_tuser), .s0_axis_tready(s0_axis_tready),
        .s1_axis_tdata(s1_axis_tdata), .s1_axis_tvalid(s1_axis_tvalid),
        .s1_axis_tlast(s1_axis_tlast), .s1_axis_tuser(s1_axis_tuser), .s1_axis_tready(s1_axis_tready),
        .m0_axis_tdata(m0_axis_tdata), .m0_axis_tvalid(m0_axis_tvalid),
        .m0_axis_tlast(m0_axis_tlast), .m0_axis_tuser(m0_axis_tuser),
        .m1_axis_tdata(m1_axis_tdata), .m1_axis_tvalid(m1_axis_tvalid),
        .m1_axis_tlast(m1_axis_tlast), .m1_axis_tuser(m1_axis_tuser),
        .eng_sm4_vld(eng_sm4_vld), .eng_sm4_key(eng_sm4_key), .eng_sm4_sel(eng_sm4_sel),
        .eng_s_axis_tdata(eng_s_axis_tdata), .eng_s_axis_tvalid(eng_s_axis_tvalid),
        .eng_s_axis_tlast(eng_s_axis_tlast), .eng_s_axis_tuser(eng_s_axis_tuser),
        .eng_s_axis_tready(eng_s_axis_tready),
        .eng_m_axis_tdata(eng_m_axis_tdata), .eng_m_axis_tvalid(eng_m_axis_tvalid),
        .eng_m_axis_tlast(eng_m_axis_tlast), .eng_m_axis_tuser(eng_m_axis_tuser),
        .busy(busy), .err_orphan(err_orphan)
    );

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    int vldCount = 0, vldCycle = 0, firstXferCycle = -1;
    int pushedPkts = 0, poppedPkts = 0;
    bit holdOut = 1'b0, backpressure = 1'b0, orphanReq = 1'b0;
    logic [16:0] expQ0[$];
    logic [16:0] expQ1[$];
    int grantOrder[$];
    logic [7:0]  inBuf[$];
    logic [16:0] outQ[$];
    logic [127:0] stubKey;
    logic         stubSel;

    // Stand-in "cipher": byte XOR key byte XOR mode mask, so a wrong key or mode is visible.
    function automatic logic [7:0] cipherByte(input logic [127:0] k, input logic s,
                                              input logic [7:0] b, input int idx);
        logic [7:0] kb;
        kb = k[127 - 8*(idx % 16) -: 8];
        return b ^ kb ^ {8{s}};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Stub engine: captures key at load, zero-pads each packet to 16 bytes, emits with optional hold/gaps.
    always @(posedge clk or negedge rst_n) begin
        int padLen;
        logic [7:0] b;
        if (!rst_n) begin
            stubKey <= '0;
            stubSel <= 1'b0;
            inBuf.delete();
            outQ.delete();
            eng_s_axis_tready <= 1'b0;
            eng_m_axis_tvalid <= 1'b0;
            eng_m_axis_tdata  <= 8'h00;
            eng_m_axis_tlast  <= 1'b0;
            eng_m_axis_tuser  <= 8'h00;
        end else begin
            if (eng_sm4_vld) begin
                stubKey <= eng_sm4_key;
                stubSel <= eng_sm4_sel;
            end
            if (eng_s_axis_tvalid && eng_s_axis_tready) begin
                inBuf.push_back(eng_s_axis_tdata);
                if (eng_s_axis_tlast) begin
                    padLen = ((inBuf.size() + 15) / 16) * 16;
                    for (int i = 0; i < padLen; i++) begin
                        b = (i < inBuf.size()) ? inBuf[i] : 8'h00;
                        outQ.push_back({i == padLen - 1, 8'(i), cipherByte(stubKey, stubSel, b, i)});
                    end
                    inBuf.delete();
                end
            end
            eng_s_axis_tready <= backpressure ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (orphanReq) begin
                eng_m_axis_tvalid <= 1'b1;
                eng_m_axis_tdata  <= 8'hA5;
                eng_m_axis_tlast  <= 1'b1;
                eng_m_axis_tuser  <= 8'h00;
            end else if (!holdOut && outQ.size() > 0 && (!backpressure || $urandom_range(0, 3) != 0)) begin
                {eng_m_axis_tlast, eng_m_axis_tuser, eng_m_axis_tdata} <= outQ.pop_front();
                eng_m_axis_tvalid <= 1'b1;
            end else begin
                eng_m_axis_tvalid <= 1'b0;
            end
        end
    end

    // Monitor: in-flight bookkeeping and per-channel output scoreboard, sampled mid-cycle.
    always @(negedge clk) begin
        logic [16:0] e;
        if (rst_n) begin
            cycle++;
            if (eng_sm4_vld) begin
                vldCount++;
                vldCycle = cycle;
                checkOutput("no_inflight_at_load", 128'(pushedPkts - poppedPkts), 128'd0);
            end
            if (eng_m_axis_tvalid && eng_m_axis_tlast && pushedPkts > poppedPkts) poppedPkts++;
            if (eng_s_axis_tvalid && eng_s_axis_tready && eng_s_axis_tlast) pushedPkts++;
            if (eng_s_axis_tvalid && firstXferCycle < 0) firstXferCycle = cycle;
            if (eng_m_axis_tvalid) checkOutput("m_exclusive", m0_axis_tvalid & m1_axis_tvalid, 1'b0);
            if (m0_axis_tvalid) begin
                checkOutput("m0_has_expected", expQ0.size() > 0, 1'b1);
                if (expQ0.size() > 0) begin
                    e = expQ0.pop_front();
                    checkOutput("m0_beat", {m0_axis_tlast, m0_axis_tuser, m0_axis_tdata}, e);
                end
            end
            if (m1_axis_tvalid) begin
                checkOutput("m1_has_expected", expQ1.size() > 0, 1'b1);
                if (expQ1.size() > 0) begin
                    e = expQ1.pop_front();
                    checkOutput("m1_beat", {m1_axis_tlast, m1_axis_tuser, m1_axis_tdata}, e);
                end
            end
        end
    end

    task automatic driveCh(input int ch, input logic v, input logic [7:0] d, input logic l, input logic [7:0] u);
        if (ch == 0) begin
            s0_axis_tvalid = v; s0_axis_tdata = d; s0_axis_tlast = l; s0_axis_tuser = u;
        end else begin
            s1_axis_tvalid = v; s1_axis_tdata = d; s1_axis_tlast = l; s1_axis_tuser = u;
        end
    endtask

    // Sends one packet on channel ch (called at a negedge) and queues its expected padded output.
    task automatic applyStimulus(input int ch, input int len, input bit countUp);
        logic [7:0]   pkt[$];
        logic [127:0] k;
        logic         s;
        int           waitN, padLen;
        k = (ch == 0) ? key0 : key1;
        s = (ch == 0) ? sel0 : sel1;
        for (int i = 0; i < len; i++) pkt.push_back(countUp ? 8'(i) : 8'($urandom));
        for (int i = 0; i < len; i++) begin
            driveCh(ch, 1'b1, pkt[i], i == len - 1, 8'($urandom));
            waitN = 0;
            #1;
            while (!((ch == 0) ? s0_axis_tready : s1_axis_tready) && waitN < TIMEOUT) begin
                @(negedge clk);
                #1;
                waitN++;
            end
            checkOutput($sformatf("ch%0d_ready_in_time", ch), waitN < TIMEOUT, 1'b1);
            if (waitN >= TIMEOUT) break;
            if (i == 0) grantOrder.push_back(ch);
            if (i == len - 1) begin
                padLen = ((len + 15) / 16) * 16;
                for (int j = 0; j < padLen; j++) begin
                    if (ch == 0) expQ0.push_back({j == padLen - 1, 8'(j), cipherByte(k, s, (j < len) ? pkt[j] : 8'h00, j)});
                    else         expQ1.push_back({j == padLen - 1, 8'(j), cipherByte(k, s, (j < len) ? pkt[j] : 8'h00, j)});
                end
            end
            @(negedge clk);
        end
        driveCh(ch, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic waitIdle(input string tag);
        int n;
        n = 0;
        while ((busy || expQ0.size() > 0 || expQ1.size() > 0) && n < TIMEOUT) begin
            @(negedge clk);
            n++;
        end
        checkOutput(tag, n < TIMEOUT, 1'b1);
    endtask

    initial begin
        #(400000);
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int vldBefore, pushedBefore;
        rst_n = 1'b0;
        key0 = 128'h0123456789ABCDEFFEDCBA9876543210;
        sel0 = 1'b0;
        key1 = {$urandom, $urandom, $urandom, $urandom};
        sel1 = 1'b1;
        driveCh(0, 1'b0, 8'h00, 1'b0, 8'h00);
        driveCh(1, 1'b0, 8'h00, 1'b0, 8'h00);
        repeat (3) @(negedge clk);

        $display("[TB] reset values");
        checkOutput("rst_busy", busy, 1'b0);
        checkOutput("rst_err_orphan", err_orphan, 1'b0);
        checkOutput("rst_s0_tready", s0_axis_tready, 1'b0);
        checkOutput("rst_s1_tready", s1_axis_tready, 1'b0);
        checkOutput("rst_eng_vld", eng_sm4_vld, 1'b0);
        checkOutput("rst_eng_tvalid", eng_s_axis_tvalid, 1'b0);
        checkOutput("rst_eng_key", eng_sm4_key, 128'd0);
        checkOutput("rst_m0_tvalid", m0_axis_tvalid, 1'b0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] first 16-byte packet on ch0");
        firstXferCycle = -1;
        applyStimulus(0, 16, 1'b1);
        waitIdle("idle_after_first");
        checkOutput("first_load_count", vldCount, 1);
        checkOutput("key_wait_latency", 128'(firstXferCycle - vldCycle), 128'(KEY_WAIT + 1));

        $display("[TB] short packet is padded to 16 bytes");
        applyStimulus(0, 5, 1'b0);
        waitIdle("idle_after_short");
        checkOutput("short_inflight_zero", 128'(pushedPkts - poppedPkts), 128'd0);

        $display("[TB] three back-to-back ch0 packets");
        for (int p = 0; p < 3; p++) applyStimulus(0, 16, 1'b0);
        waitIdle("idle_after_b2b");
        checkOutput("single_load_total", vldCount, 1);

        $display("[TB] both channels contending with engine backpressure");
        backpressure = 1'b1;
        grantOrder.delete();
        vldBefore = vldCount;
        fork
            for (int p = 0; p < 4; p++) applyStimulus(0, 16, 1'b0);
            for (int p = 0; p < 4; p++) applyStimulus(1, 16, 1'b0);
        join
        waitIdle("idle_after_contend");
        checkOutput("grant_count", grantOrder.size(), 8);
        for (int i = 1; i < grantOrder.size(); i++)
            checkOutput($sformatf("grant_alternates_%0d", i), grantOrder[i] != grantOrder[i-1], 1'b1);
        checkOutput("reload_per_switch", vldCount - vldBefore, 8);
        backpressure = 1'b0;

        $display("[TB] channel-ID FIFO full blocks new grants");
        holdOut = 1'b1;
        pushedBefore = pushedPkts;
        for (int p = 0; p < MAX_OUT; p++) applyStimulus(0, 16, 1'b0);
        fork
            applyStimulus(0, 16, 1'b0);
            begin
                repeat (60) @(negedge clk);
                checkOutput("full_no_new_packet", pushedPkts - pushedBefore, MAX_OUT);
                checkOutput("full_s0_tready", s0_axis_tready, 1'b0);
                checkOutput("full_busy", busy, 1'b1);
                holdOut = 1'b0;
            end
        join
        waitIdle("idle_after_full");
        checkOutput("full_then_accepted", pushedPkts - pushedBefore, MAX_OUT + 1);

        $display("[TB] orphan engine beat");
        checkOutput("orphan_clear_before", err_orphan, 1'b0);
        @(negedge clk);
        orphanReq = 1'b1;
        @(negedge clk);
        orphanReq = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("orphan_set", err_orphan, 1'b1);
        applyStimulus(1, 16, 1'b0);
        waitIdle("idle_after_orphan");
        checkOutput("orphan_sticky", err_orphan, 1'b1);
        rst_n = 1'b0;
        #1;
        checkOutput("orphan_cleared_by_reset", err_orphan, 1'b0);
        checkOutput("busy_cleared_by_reset", busy, 1'b0);
        repeat (2) @(negedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
